// File: rtl/spi_command_dispatcher.sv
// spi_command_dispatcher: decodes CS-framed SPI commands and dispatches whole records to per-channel FIFOs.
// Records only become visible on commit; partial records are aborted, records to full channels are dropped.
module spi_command_dispatcher #(
    parameter int         NumChannels = 4,
    parameter int         RecordBytes = 16,
    parameter int         SlotBits    = 8,
    parameter logic [7:0] CmdStatus   = 8'h01,
    parameter logic [7:0] CmdWrite    = 8'h02,
    parameter logic [7:0] CmdFlush    = 8'h03
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            spi_cs,
    input  logic [7:0]                      rx_word,
    input  logic                            rx_valid,
    output logic [7:0]                      tx_word,
    input  logic [NumChannels*SlotBits-1:0] ch_free_slots,
    output logic [7:0]                      ch_data,
    output logic [NumChannels-1:0]          ch_write_en,
    output logic [NumChannels-1:0]          ch_commit,
    output logic [NumChannels-1:0]          ch_abort,
    output logic [NumChannels-1:0]          ch_flush,
    output logic [7:0]                      drop_count,
    output logic                            busy
);
    localparam int CntBits = $clog2(RecordBytes);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] STATUS     = 3'd1;
    localparam logic [2:0] SELECT     = 3'd2;
    localparam logic [2:0] RECEIVE    = 3'd3;
    localparam logic [2:0] FLUSH_MASK = 3'd4;
    localparam logic [2:0] DISCARD    = 3'd5;

    logic [2:0]             state;
    logic [3:0]             ch;
    logic [CntBits-1:0]     byte_cnt;
    logic                   room;
    logic [4:0]             tx_idx;
    logic                   accept;
    logic                   ch_has_room;
    logic                   room_now;
    logic                   last_byte;
    logic                   known_op;
    logic                   drop_hit;
    logic [7:0]             status_slots;
    logic [7:0]             ch0_slots;
    logic [NumChannels-1:0] ch_onehot;
    logic [NumChannels-1:0] flush_mask;

    function automatic logic [7:0] slots8(input int i);
        logic [31:0] w;
        w = 32'(ch_free_slots[i*SlotBits +: SlotBits]);
        return w[7:0];
    endfunction

    always_comb begin
        ch_has_room  = 1'b0;
        status_slots = 8'h00;
        ch_onehot    = '0;
        flush_mask   = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (ch == 4'(i)) begin
                ch_has_room  = ch_free_slots[i*SlotBits +: SlotBits] != '0;
                ch_onehot[i] = 1'b1;
            end
            if (tx_idx == 5'(i))
                status_slots = slots8(i);
            flush_mask[i] = (i < 8) && rx_word[3'(i % 8)];
        end
    end

    assign ch0_slots = slots8(0);
    assign accept    = rx_valid && !spi_cs;
    // Room is decided once at the first byte of a record and held for the rest of it
    assign room_now  = (byte_cnt == '0) ? ch_has_room : room;
    assign last_byte = byte_cnt == CntBits'(RecordBytes - 1);
    assign known_op  = rx_word == CmdStatus || rx_word == CmdWrite || rx_word == CmdFlush;
    assign drop_hit  = spi_cs ? (state == RECEIVE && byte_cnt != '0)
                     : accept && ((state == IDLE && !known_op)
                               || (state == SELECT && rx_word >= 8'(NumChannels))
                               || (state == RECEIVE && last_byte && !room_now));
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            byte_cnt    <= '0;
            room        <= 1'b0;
            tx_idx      <= '0;
            tx_word     <= 8'h00;
            ch_data     <= 8'h00;
            ch_write_en <= '0;
            ch_commit   <= '0;
            ch_abort    <= '0;
            ch_flush    <= '0;
            drop_count  <= 8'h00;
        end else begin
            ch_write_en <= '0;
            ch_commit   <= '0;
            ch_abort    <= '0;
            ch_flush    <= '0;
            if (drop_hit && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            tx_word <= (state == IDLE) ? ch0_slots : (state == STATUS) ? status_slots : 8'h00;
            if (spi_cs) begin
                state <= IDLE;
                if (state == RECEIVE && byte_cnt != '0 && room)
                    ch_abort <= ch_onehot;
            end else if (rx_valid) begin
                case (state)
                    IDLE: begin
                        tx_idx <= 5'd1;
                        state  <= (rx_word == CmdStatus) ? STATUS :
                                  (rx_word == CmdWrite)  ? SELECT :
                                  (rx_word == CmdFlush)  ? FLUSH_MASK : DISCARD;
                    end
                    STATUS: begin
                        if (tx_idx < 5'(NumChannels))
                            tx_idx <= tx_idx + 5'd1;
                    end
                    SELECT: begin
                        if (rx_word >= 8'(NumChannels)) begin
                            state <= DISCARD;
                        end else begin
                            ch       <= rx_word[3:0];
                            byte_cnt <= '0;
                            state    <= RECEIVE;
                        end
                    end
                    RECEIVE: begin
                        if (byte_cnt == '0)
                            room <= ch_has_room;
                        if (room_now) begin
                            ch_data     <= rx_word;
                            ch_write_en <= ch_onehot;
                        end
                        if (last_byte && room_now)
                            ch_commit <= ch_onehot;
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    end
                    FLUSH_MASK: begin
                        ch_flush <= flush_mask;
                        state    <= DISCARD;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
